cache_refill_responder: RTL

- Memory-side responder serving the direct-mapped data cache's miss refills and write-through stores.
- Holds the backing word memory and answers one request at a time after a fixed, parameterised latency.
- Uses a valid/ready request channel and a valid/ready response channel.
- Sits between the cache and the data-memory region of the RISC-V CPU, modelling main-memory delay so the cache and pipeline stall logic can be exercised.

---
 rtl/cache_refill_responder_if.sv | 26 ++
 rtl/cache_refill_responder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cache_refill_responder_if.sv
// Request/response bus between the data cache and the refill responder.
// The cache drives the master modport, the responder implements the slave modport.
interface cache_refill_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  busy_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );
endinterface

// File: rtl/cache_refill_responder.sv
// Memory-side responder for the data cache: serves refill reads and
// write-through stores from a backing word memory, one request at a time,
// after a fixed LATENCY. Used to exercise cache and pipeline stall logic.
// Optional macro PERF_STALL_CNT_EN adds a saturating 32-bit busy-cycle
// counter on output stall_cnt_o.
module cache_refill_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 4
) (
    input logic clk,
    input logic rst,
    cache_refill_responder_if.slave bus
`ifdef PERF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                    state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [MEM_ADDR_WIDTH-1:0] lat_idx;
    logic                      lat_we;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_data;
    logic [MEM_ADDR_WIDTH-1:0] req_idx;
    logic                      access;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // Byte offset and the address bits above the memory depth are dropped,
    // so addresses alias modulo the memory size.
    assign req_idx = bus.req_addr_i[MEM_ADDR_WIDTH+1:2];

    // The single cycle on which the latched request touches memory.
    assign access = (state == ST_WAIT) && (cnt == '0);

    assign bus.req_ready_o = (state == ST_IDLE);
    assign bus.busy_o      = (state != ST_IDLE);
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = rsp_data;

    // Request/latency/response sequencing with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        lat_idx   <= req_idx;
                        lat_we    <= bus.req_we_i;
                        lat_wdata <= bus.req_wdata_i;
                        cnt       <= CNT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= lat_we ? lat_wdata : mem[lat_idx];
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Store path into the backing memory; the array itself is never reset,
    // and a reset before the access edge leaves the FSM idle so no write occurs.
    always_ff @(posedge clk) begin
        if (access && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

`ifdef PERF_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Counts every busy cycle, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state != ST_IDLE) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule
